slowclk_edge_recover: RTL and testbench
=======================================

// Module: slowclk_edge_recover
// PURPOSE
// Converts an asynchronous slow clock source (external oscillator pin or debounced manual
// STEP button) into sysclk-domain enable pulses for the SAP datapath.
// - clken: one sysclk cycle, marks slow rising edge.  clken2: one cycle, marks slow falling edge.
// - slowclk_out: registered level copy of the recovered slow clock, for LEDs.
// - Sits between the board clock/switch pins and the CPU; honours the CPU HLT line.
// PARAMETERS
// DEBOUNCE   1000000  sysclk cycles step_btn must stay stable before its new level is accepted (>=2)
// STEP_WIDTH 50000    sysclk cycles slowclk_out stays high for one manual step (>=2)
// PORTS
// sysclk       in   1  system clock; all logic on posedge
// reset        in   1  synchronous, active-low reset (0 = reset)
// slowclk_in   in   1  asynchronous external slow clock, used in RUN mode
// step_btn     in   1  asynchronous, bouncy push-button, 1 = pressed, used in STEP mode
// mode         in   2  00 RUN, 01 STEP, 1x STOP; synchronous to sysclk
// hlt          in   1  CPU halt request; synchronous to sysclk
// clken        out  1  1-cycle pulse, slow rising edge
// clken2       out  1  1-cycle pulse, slow falling edge
// slowclk_out  out  1  recovered slow clock level
// step_busy    out  1  1 while a manual step is in progress
// halted       out  1  1 when hlt=1 and slowclk_out=0
// BEHAVIOUR
// Reset (reset=0 at a posedge): all outputs 0, FSM IDLE, synchronisers 0, debounce counter 0, stable_btn 0.
// Synchronisers and debounce:
// - Each async input goes through 2 flops (s1, s2); a third flop s3 holds the previous s2.
// - RUN rise event: s2 & ~s3.  RUN fall event: ~s2 & s3.
// - Latency: slowclk_in first sampled 1 at edge k -> rise event registers at edge k+2.
//   clken is high in the cycle after edge k+2, for exactly 1 cycle.
// - step_btn: counter resets to 0 whenever synced button equals stable_btn.
//   Otherwise it increments; on reaching DEBOUNCE-1, stable_btn takes the synced value.
//   A press event is a 0->1 transition of stable_btn.
// FSM states: IDLE, RUN_HI, STEP_HI, STEP_WAIT.
// - IDLE, mode=RUN, rise event, hlt=0 -> clken=1, slowclk_out=1, go to RUN_HI.
// - RUN_HI, fall event -> clken2=1, slowclk_out=0, go to IDLE.
//   A rise event while in RUN_HI is ignored.
// - IDLE, mode=STEP, press event, hlt=0 -> clken=1, slowclk_out=1, step_busy=1, counter cleared,
//   go to STEP_HI.
// - STEP_HI counts STEP_WIDTH cycles from entry.
//   On the last count -> clken2=1, slowclk_out=0, go to STEP_WAIT.
// - STEP_WAIT, stable_btn=0 -> step_busy=0, go to IDLE.
//   One press gives exactly one clken/clken2 pair; holding the button does not repeat.
// - mode=STOP, or hlt=1: IDLE takes no transition; no new clken is generated.
// Simultaneous events and mid-operation changes:
// - A slow high phase already started always completes with its clken2, whatever mode or hlt do.
//   RUN_HI exits only on a fall event; STEP_HI is never truncated.
// - A mode change takes effect only in IDLE.
//   A press arriving in RUN mode, or a rise event arriving in STEP mode, is dropped, not queued.
// - hlt and a rise/press in the same cycle: hlt wins, no clken.
// - clken and clken2 are never both 1 in the same cycle; every clken is followed by exactly one clken2.
// - Reset mid-phase: outputs drop to 0 next cycle and no clken2 is emitted.
// - slowclk_in pulses shorter than 2 sysclk cycles may be missed. This is accepted; no spurious pulse is allowed.
// TESTING
// (Bench uses DEBOUNCE=4, STEP_WIDTH=5.)
// 1. RUN, hlt=0, slowclk_in period 20 cycles at 50% duty:
//    -> clken at edge k+2 after each rise, clken2 10 cycles later.
//    -> slowclk_out period 20; 1-cycle pulses only.
// 2. STEP mode; step_btn bounces 0/1 every cycle for 3 cycles, then holds 1 for 20 cycles:
//    -> exactly one clken; slowclk_out high 5 cycles; then one clken2.
//    -> step_busy held until button release plus debounce.
// 3. RUN; hlt=1 raised while slowclk_out=1:
//    -> clken2 still issued on next fall; then no clken for 3 further slowclk_in periods; halted=1.
//    -> hlt=0 -> clken resumes on next rise.
// 4. Mode switched RUN->STEP in the middle of RUN_HI:
//    -> clken2 on slowclk_in fall; later slowclk_in rises give no clken.
//    -> a debounced press gives one step.
// 5. reset=0 for 1 cycle in the middle of STEP_HI:
//    -> clken, clken2, slowclk_out, step_busy all 0 next cycle, and no clken2 afterwards.
//    -> a new press after reset=1 produces a normal step.
// 6. mode=STOP, slowclk_in toggling, presses applied: -> clken=clken2=0 throughout.

Source files
------------

// File: rtl/slowclk_edge_recover_if.sv
// rtl/slowclk_edge_recover_if.sv - slow clock source / enable pulse bundle
interface slowclk_edge_recover_if;
  logic       slowclk_in;
  logic       step_btn;
  logic [1:0] mode;
  logic       hlt;
  logic       clken;
  logic       clken2;
  logic       slowclk_out;
  logic       step_busy;
  logic       halted;

  modport master (
    output slowclk_in, step_btn, mode, hlt,
    input  clken, clken2, slowclk_out, step_busy, halted
  );

  modport slave (
    input  slowclk_in, step_btn, mode, hlt,
    output clken, clken2, slowclk_out, step_busy, halted
  );
endinterface

// File: rtl/slowclk_edge_recover.sv
// rtl/slowclk_edge_recover.sv - async slow clock / step button to sysclk enable pulses
module slowclk_edge_recover #(
  parameter int DEBOUNCE   = 1000000,
  parameter int STEP_WIDTH = 50000
) (
  input  logic                  sysclk,
  input  logic                  reset,
  slowclk_edge_recover_if.slave bus
);

  localparam int DB_W = (DEBOUNCE   > 1) ? $clog2(DEBOUNCE)   : 1;
  localparam int SW_W = (STEP_WIDTH > 1) ? $clog2(STEP_WIDTH) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [SW_W-1:0] SW_LAST = SW_W'(STEP_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN_HI, STEP_HI, STEP_WAIT} state_t;

  logic clk_s1, clk_s2, clk_s3;
  logic btn_s1, btn_s2;
  logic [DB_W-1:0] db_cnt;
  logic stable_btn, stable_prev;

  state_t state, state_n;
  logic [SW_W-1:0] step_cnt, step_cnt_n;
  logic clken_q, clken_n;
  logic clken2_q, clken2_n;
  logic slowclk_q, slowclk_n;
  logic busy_q, busy_n;

  logic rise_evt, fall_evt, press_evt;
  logic mode_run, mode_step;

  // Two-flop synchronisers plus a history flop on the slow clock for edge detection
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      clk_s1 <= 1'b0;
      clk_s2 <= 1'b0;
      clk_s3 <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      clk_s1 <= bus.slowclk_in;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      btn_s1 <= bus.step_btn;
      btn_s2 <= btn_s1;
    end
  end

  assign rise_evt = clk_s2 & ~clk_s3;
  assign fall_evt = ~clk_s2 & clk_s3;

  // Button debounce: accept a new level only after it has differed for DEBOUNCE cycles
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      db_cnt      <= '0;
      stable_btn  <= 1'b0;
      stable_prev <= 1'b0;
    end else begin
      stable_prev <= stable_btn;
      if (btn_s2 == stable_btn) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt     <= '0;
        stable_btn <= btn_s2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press_evt = stable_btn & ~stable_prev;
  assign mode_run  = (bus.mode == 2'b00);
  assign mode_step = (bus.mode == 2'b01);

  // Next-state and next-output decode; mode and hlt only matter while idle
  always_comb begin
    state_n    = state;
    step_cnt_n = step_cnt;
    clken_n    = 1'b0;
    clken2_n   = 1'b0;
    slowclk_n  = slowclk_q;
    busy_n     = busy_q;
    unique case (state)
      IDLE: begin
        if (!bus.hlt) begin
          if (mode_run && rise_evt) begin
            clken_n   = 1'b1;
            slowclk_n = 1'b1;
            state_n   = RUN_HI;
          end else if (mode_step && press_evt) begin
            clken_n    = 1'b1;
            slowclk_n  = 1'b1;
            busy_n     = 1'b1;
            step_cnt_n = '0;
            state_n    = STEP_HI;
          end
        end
      end
      RUN_HI: begin
        if (fall_evt) begin
          clken2_n  = 1'b1;
          slowclk_n = 1'b0;
          state_n   = IDLE;
        end
      end
      STEP_HI: begin
        if (step_cnt == SW_LAST) begin
          clken2_n  = 1'b1;
          slowclk_n = 1'b0;
          state_n   = STEP_WAIT;
        end else begin
          step_cnt_n = step_cnt + 1'b1;
        end
      end
      STEP_WAIT: begin
        if (!stable_btn) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register with registered pulse and level outputs
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state     <= IDLE;
      step_cnt  <= '0;
      clken_q   <= 1'b0;
      clken2_q  <= 1'b0;
      slowclk_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      step_cnt  <= step_cnt_n;
      clken_q   <= clken_n;
      clken2_q  <= clken2_n;
      slowclk_q <= slowclk_n;
      busy_q    <= busy_n;
    end
  end

  assign bus.clken       = clken_q;
  assign bus.clken2      = clken2_q;
  assign bus.slowclk_out = slowclk_q;
  assign bus.step_busy   = busy_q;
  assign bus.halted      = bus.hlt & ~slowclk_q;

endmodule

// File: tb/tb_slowclk_edge_recover.sv
// tb/tb_slowclk_edge_recover.sv - directed bench for slowclk_edge_recover
module tb_slowclk_edge_recover;

  logic sysclk = 1'b0;
  logic reset  = 1'b0;
  slowclk_edge_recover_if bus_if ();

  slowclk_edge_recover #(.DEBOUNCE(4), .STEP_WIDTH(5)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus_if)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc, n_rise, n_fall, n_hi, rise_cyc, fall_cyc, busy_on, busy_off;
  int n_both = 0;
  int n_wide = 0;
  logic p_clken = 1'b0, p_clken2 = 1'b0, p_busy = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_mon();
    cyc = 0; n_rise = 0; n_fall = 0; n_hi = 0;
    rise_cyc = -1; fall_cyc = -1; busy_on = -1; busy_off = -1;
  endtask

  // One sysclk cycle; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge sysclk);
    #1;
    cyc++;
    if (bus_if.clken)  begin n_rise++; rise_cyc = cyc; end
    if (bus_if.clken2) begin n_fall++; fall_cyc = cyc; end
    if (bus_if.slowclk_out) n_hi++;
    if (bus_if.clken && bus_if.clken2) n_both++;
    if ((bus_if.clken && p_clken) || (bus_if.clken2 && p_clken2)) n_wide++;
    if (bus_if.step_busy && !p_busy) busy_on = cyc;
    if (!bus_if.step_busy && p_busy) busy_off = cyc;
    p_clken  = bus_if.clken;
    p_clken2 = bus_if.clken2;
    p_busy   = bus_if.step_busy;
  endtask

  initial begin
    bus_if.slowclk_in = 1'b0;
    bus_if.step_btn   = 1'b0;
    bus_if.mode       = 2'b00;
    bus_if.hlt        = 1'b0;
    clear_mon();

    // reset state
    reset = 1'b0;
    repeat (3) tick();
    check("rst_clken", bus_if.clken, 0);
    check("rst_clken2", bus_if.clken2, 0);
    check("rst_slowclk_out", bus_if.slowclk_out, 0);
    check("rst_step_busy", bus_if.step_busy, 0);
    check("rst_halted", bus_if.halted, 0);
    reset = 1'b1;
    tick();

    // 1: RUN, period 20, 50% duty
    clear_mon();
    bus_if.mode = 2'b00;
    for (int i = 0; i < 60; i++) begin
      bus_if.slowclk_in = ((i % 20) < 10);
      tick();
    end
    check("run_n_clken", n_rise, 3);
    check("run_n_clken2", n_fall, 3);
    check("run_last_clken_cyc", rise_cyc, 43);
    check("run_last_clken2_cyc", fall_cyc, 53);
    check("run_high_cycles", n_hi, 30);

    // 2: STEP, bouncy press then hold, then release
    clear_mon();
    bus_if.mode = 2'b01;
    bus_if.slowclk_in = 1'b0;
    bus_if.step_btn = 1'b1; tick();
    bus_if.step_btn = 1'b0; tick();
    bus_if.step_btn = 1'b1; tick();
    repeat (20) tick();
    bus_if.step_btn = 1'b0;
    repeat (20) tick();
    check("step_n_clken", n_rise, 1);
    check("step_n_clken2", n_fall, 1);
    check("step_clken_cyc", rise_cyc, 9);
    check("step_clken2_cyc", fall_cyc, 14);
    check("step_high_cycles", n_hi, 5);
    check("step_busy_on", busy_on, 9);
    check("step_busy_off", busy_off, 30);

    // 3: RUN with hlt raised during the high phase
    clear_mon();
    bus_if.mode = 2'b00;
    for (int i = 0; i < 100; i++) begin
      bus_if.slowclk_in = ((i % 20) < 10);
      bus_if.hlt = (i >= 5 && i < 80);
      tick();
      if (cyc == 6)  check("hlt_halted_while_high", bus_if.halted, 0);
      if (cyc == 15) check("hlt_halted_after_fall", bus_if.halted, 1);
      if (cyc == 80) check("hlt_no_clken_while_halted", n_rise, 1);
    end
    check("hlt_n_clken", n_rise, 2);
    check("hlt_n_clken2", n_fall, 2);
    check("hlt_resume_clken_cyc", rise_cyc, 83);
    check("hlt_resume_clken2_cyc", fall_cyc, 93);

    // 4: RUN -> STEP switch inside RUN_HI, then one press
    clear_mon();
    for (int i = 0; i < 60; i++) begin
      bus_if.slowclk_in = ((i % 20) < 10);
      bus_if.mode = (i >= 5) ? 2'b01 : 2'b00;
      tick();
    end
    check("sw_clken2_cyc", fall_cyc, 13);
    check("sw_n_clken_before_press", n_rise, 1);
    bus_if.slowclk_in = 1'b0;
    for (int i = 60; i < 85; i++) begin
      bus_if.step_btn = (i < 70);
      tick();
    end
    check("sw_n_clken", n_rise, 2);
    check("sw_step_clken_cyc", rise_cyc, 67);
    check("sw_step_clken2_cyc", fall_cyc, 72);

    // 5: reset pulse inside STEP_HI, then a fresh press
    clear_mon();
    bus_if.mode = 2'b01;
    for (int i = 0; i < 50; i++) begin
      bus_if.step_btn = (i < 8) || (i >= 20 && i < 35);
      reset = (i != 8);
      tick();
      if (cyc == 9) begin
        check("rstmid_clken", bus_if.clken, 0);
        check("rstmid_clken2", bus_if.clken2, 0);
        check("rstmid_slowclk_out", bus_if.slowclk_out, 0);
        check("rstmid_step_busy", bus_if.step_busy, 0);
      end
      if (cyc == 20) begin
        check("rstmid_no_clken2", n_fall, 0);
        check("rstmid_first_clken_cyc", rise_cyc, 7);
      end
    end
    check("rstmid_n_clken", n_rise, 2);
    check("rstmid_new_clken_cyc", rise_cyc, 27);
    check("rstmid_new_clken2_cyc", fall_cyc, 32);

    // 6: STOP mode with both sources active
    clear_mon();
    bus_if.mode = 2'b10;
    for (int i = 0; i < 80; i++) begin
      bus_if.slowclk_in = ((i % 20) < 10);
      bus_if.step_btn = (i >= 10 && i < 30) || (i >= 50 && i < 70);
      tick();
    end
    check("stop_n_clken", n_rise, 0);
    check("stop_n_clken2", n_fall, 0);

    check("never_both_pulses", n_both, 0);
    check("pulses_one_cycle", n_wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
